mc_control_fsm: RTL and testbench
=================================

// Module: mc_control_fsm
// PURPOSE
//  Multicycle MIPS control unit. Sequences fetch/decode/execute/memory/writeback for one
//  instruction at a time and drives every datapath control. Selects the immediate extension
//  mode (sign / zero / lui) for the extend unit. Waits on a ready handshake for memory access,
//  with a timeout. Sits between the instruction register opcode/funct fields and the shared
//  ALU, register-file, extend-unit and memory-port muxes.
// PARAMETERS
//  MEM_TIMEOUT  255  max cycles waiting on mem_ready before entering TRAP (1..255)
// PORTS
//  clk          in   1  single clock, rising edge
//  rst_n        in   1  asynchronous active-low reset
//  opcode       in   6  IR[31:26], valid from DECODE onward
//  funct        in   6  IR[5:0]
//  alu_zero     in   1  ALU zero flag, sampled in BRANCH
//  mem_ready    in   1  memory completes current read/write this cycle
//  pc_we        out  1  PC write enable
//  ir_we        out  1  instruction register write enable
//  mem_rd       out  1  memory read request (held until mem_ready)
//  mem_wr       out  1  memory write request (held until mem_ready)
//  iord         out  1  0=PC addresses memory, 1=ALUOut addresses memory
//  ext_mode     out  2  00 sign-extend, 01 zero-extend, 10 imm<<16 (lui), 11 unused
//  alu_src_a    out  1  0=PC, 1=regA
//  alu_src_b    out  2  00 regB, 01 const 4, 10 extended imm, 11 extended imm<<2
//  alu_op       out  3  000 add, 001 sub, 010 funct-decoded, 011 and, 100 or, 101 slt, 110 passB
//  pc_src       out  2  00 ALU result, 01 ALUOut, 10 jump target
//  reg_we       out  1  register file write enable
//  reg_dst      out  1  0=rt, 1=rd
//  mem_to_reg   out  1  1=write MDR to register
//  trap         out  1  sticky: illegal opcode or memory timeout
//  state        out  4  current state code (debug)
// BEHAVIOUR
//  States: IDLE0 FETCH1 DECODE2 MEMADR3 MEMRD4 MEMWB5 MEMWR6 REX7 RWB8 BRANCH9 IEX10 IWB11 JUMP12 TRAP13.
//  Reset: state=IDLE, timeout counter=0, trap=0; all outputs 0 while in IDLE. IDLE->FETCH next cycle.
//  Outputs decode from the registered state. The only input-gated outputs are the pc_we/ir_we
//  handshake and the branch pc_we.
//  FETCH: mem_rd=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=add, pc_src=00. Stay until
//   mem_ready; in that cycle ir_we=1 and pc_we=1, then go to DECODE. Latency per instruction
//   is therefore >=3 cycles.
//  DECODE: alu_src_a=0, alu_src_b=11, ext_mode=sign (branch target precompute). Next state by opcode:
//   lw 100011 / sw 101011 ->MEMADR; R 000000 ->REX; beq 000100 / bne 000101 ->BRANCH;
//   addi 001000, slti 001010, andi 001100, ori 001101, lui 001111 ->IEX; j 000010 ->JUMP;
//   any other opcode ->TRAP.
//  MEMADR: alu_src_a=1, alu_src_b=10, ext_mode=sign, alu_op=add. lw->MEMRD, sw->MEMWR.
//  MEMRD: mem_rd=1, iord=1; on mem_ready ->MEMWB. MEMWB: reg_we=1, reg_dst=0, mem_to_reg=1; ->FETCH.
//  MEMWR: mem_wr=1, iord=1; on mem_ready ->FETCH.
//  REX: alu_src_a=1, alu_src_b=00, alu_op=010; ->RWB. RWB: reg_we=1, reg_dst=1; ->FETCH.
//  BRANCH: alu_src_a=1, alu_src_b=00, alu_op=sub, pc_src=01. pc_we=alu_zero for beq,
//   pc_we=!alu_zero for bne. ->FETCH.
//  IEX: alu_src_a=1, alu_src_b=10. ext_mode and alu_op by opcode: addi sign/add, slti sign/slt,
//   andi zero/and, ori zero/or, lui lui/passB. ->IWB.
//  IWB: same ext_mode/alu_op/alu_src values as IEX held; reg_we=1, reg_dst=0; ->FETCH.
//  JUMP: pc_src=10, pc_we=1; ->FETCH.
//  Timeout counter: clears on entry to FETCH/MEMRD/MEMWR. Increments each cycle waiting without
//   mem_ready. When it reaches MEM_TIMEOUT with mem_ready still 0 ->TRAP, and no ir_we/pc_we is issued.
//  mem_ready outside FETCH/MEMRD/MEMWR is ignored. If mem_ready arrives on the timeout cycle,
//   the handshake completes (no trap).
//  TRAP: trap=1, all other outputs 0, held until rst_n low. Reset mid-instruction aborts to IDLE
//   immediately (asynchronous); no partial writes are issued after reset asserts.
// TESTING
//  reset, mem_ready=1 always, add R-type -> IDLE,FETCH,DECODE,REX,RWB,FETCH; reg_we=1 and reg_dst=1 only in RWB.
//  lw with mem_ready low 3 cycles in MEMRD -> mem_rd/iord held 4 cycles, then MEMWB with mem_to_reg=1.
//  ori, then lui -> IEX ext_mode=01 alu_op=100; then ext_mode=10 alu_op=110; reg_we only in IWB.
//  beq with alu_zero=1 -> pc_we=1 in BRANCH; bne with alu_zero=1 -> pc_we=0; both return to FETCH.
//  MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH -> TRAP after 4 wait cycles, trap=1, ir_we never 1.
//  opcode 111111 -> TRAP after DECODE; rst_n pulse low mid-MEMWR -> mem_wr=0 at once, then IDLE->FETCH.

Source files
------------

// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multicycle control FSM and the datapath.
// The master side is the control unit; the slave side is the datapath.
interface mc_control_fsm_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       alu_zero;
  logic       mem_ready;
  logic       pc_we;
  logic       ir_we;
  logic       mem_rd;
  logic       mem_wr;
  logic       iord;
  logic [1:0] ext_mode;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic [1:0] pc_src;
  logic       reg_we;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       trap;
  logic [3:0] state;

  modport master (
    input  opcode, funct, alu_zero, mem_ready,
    output pc_we, ir_we, mem_rd, mem_wr, iord, ext_mode, alu_src_a, alu_src_b,
           alu_op, pc_src, reg_we, reg_dst, mem_to_reg, trap, state
  );

  modport slave (
    output opcode, funct, alu_zero, mem_ready,
    input  pc_we, ir_we, mem_rd, mem_wr, iord, ext_mode, alu_src_a, alu_src_b,
           alu_op, pc_src, reg_we, reg_dst, mem_to_reg, trap, state
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control unit: sequences one instruction at a time and drives
// every datapath select, with a bounded wait on the memory ready handshake.
module mc_control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  mc_control_fsm_if.master   ctl
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_REX    = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_IEX    = 4'd10,
    S_IWB    = 4'd11,
    S_JUMP   = 4'd12,
    S_TRAP   = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_wait_cnt;
  logic       w_mem_state;
  logic       w_waiting;
  logic       w_timeout;

  logic       w_pc_we;
  logic       w_ir_we;
  logic       w_mem_rd;
  logic       w_mem_wr;
  logic       w_iord;
  logic [1:0] w_ext_mode;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [2:0] w_alu_op;
  logic [1:0] w_pc_src;
  logic       w_reg_we;
  logic       w_reg_dst;
  logic       w_mem_to_reg;
  logic       w_trap;

  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  assign w_waiting   = w_mem_state && !ctl.mem_ready;
  // The last allowed wait cycle is the one where the count equals MEM_TIMEOUT-1.
  assign w_timeout   = w_waiting && (r_wait_cnt == TIMEOUT_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Any cycle that is not an ongoing wait leaves the count at zero for the next wait state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wait_cnt <= 8'd0;
    end else if (w_waiting && !w_timeout) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end else begin
      r_wait_cnt <= 8'd0;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_pc_we      = 1'b0;
    w_ir_we      = 1'b0;
    w_mem_rd     = 1'b0;
    w_mem_wr     = 1'b0;
    w_iord       = 1'b0;
    w_ext_mode   = 2'b00;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = 2'b00;
    w_alu_op     = 3'b000;
    w_pc_src     = 2'b00;
    w_reg_we     = 1'b0;
    w_reg_dst    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_trap       = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_next = S_FETCH;
      end
      S_FETCH: begin
        w_mem_rd    = 1'b1;
        w_alu_src_b = 2'b01;
        if (ctl.mem_ready) begin
          w_ir_we = 1'b1;
          w_pc_we = 1'b1;
          w_next  = S_DECODE;
        end else if (w_timeout) begin
          w_next = S_TRAP;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_DECODE: begin
        w_alu_src_b = 2'b11;
        case (ctl.opcode)
          OP_LW, OP_SW:                               w_next = S_MEMADR;
          OP_RTYPE:                                   w_next = S_REX;
          OP_BEQ, OP_BNE:                             w_next = S_BRANCH;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI:  w_next = S_IEX;
          OP_J:                                       w_next = S_JUMP;
          default:                                    w_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        if (ctl.opcode == OP_LW) begin
          w_next = S_MEMRD;
        end else begin
          w_next = S_MEMWR;
        end
      end
      S_MEMRD: begin
        w_mem_rd = 1'b1;
        w_iord   = 1'b1;
        if (ctl.mem_ready) begin
          w_next = S_MEMWB;
        end else if (w_timeout) begin
          w_next = S_TRAP;
        end else begin
          w_next = S_MEMRD;
        end
      end
      S_MEMWB: begin
        w_reg_we     = 1'b1;
        w_mem_to_reg = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEMWR: begin
        w_mem_wr = 1'b1;
        w_iord   = 1'b1;
        if (ctl.mem_ready) begin
          w_next = S_FETCH;
        end else if (w_timeout) begin
          w_next = S_TRAP;
        end else begin
          w_next = S_MEMWR;
        end
      end
      S_REX: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = 3'b010;
        w_next      = S_RWB;
      end
      S_RWB: begin
        w_reg_we  = 1'b1;
        w_reg_dst = 1'b1;
        w_next    = S_FETCH;
      end
      S_BRANCH: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = 3'b001;
        w_pc_src    = 2'b01;
        case (ctl.opcode)
          OP_BEQ:  w_pc_we = ctl.alu_zero;
          OP_BNE:  w_pc_we = !ctl.alu_zero;
          default: w_pc_we = 1'b0;
        endcase
        w_next = S_FETCH;
      end
      S_IEX, S_IWB: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        case (ctl.opcode)
          OP_ADDI: begin w_ext_mode = 2'b00; w_alu_op = 3'b000; end
          OP_SLTI: begin w_ext_mode = 2'b00; w_alu_op = 3'b101; end
          OP_ANDI: begin w_ext_mode = 2'b01; w_alu_op = 3'b011; end
          OP_ORI:  begin w_ext_mode = 2'b01; w_alu_op = 3'b100; end
          OP_LUI:  begin w_ext_mode = 2'b10; w_alu_op = 3'b110; end
          default: begin w_ext_mode = 2'b00; w_alu_op = 3'b000; end
        endcase
        if (r_state == S_IWB) begin
          w_reg_we = 1'b1;
          w_next   = S_FETCH;
        end else begin
          w_next = S_IWB;
        end
      end
      S_JUMP: begin
        w_pc_src = 2'b10;
        w_pc_we  = 1'b1;
        w_next   = S_FETCH;
      end
      S_TRAP: begin
        w_trap = 1'b1;
        w_next = S_TRAP;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign ctl.pc_we      = w_pc_we;
  assign ctl.ir_we      = w_ir_we;
  assign ctl.mem_rd     = w_mem_rd;
  assign ctl.mem_wr     = w_mem_wr;
  assign ctl.iord       = w_iord;
  assign ctl.ext_mode   = w_ext_mode;
  assign ctl.alu_src_a  = w_alu_src_a;
  assign ctl.alu_src_b  = w_alu_src_b;
  assign ctl.alu_op     = w_alu_op;
  assign ctl.pc_src     = w_pc_src;
  assign ctl.reg_we     = w_reg_we;
  assign ctl.reg_dst    = w_reg_dst;
  assign ctl.mem_to_reg = w_mem_to_reg;
  assign ctl.trap       = w_trap;
  assign ctl.state      = r_state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: each instruction is expanded into its expected
// per-cycle trace from the instruction-class rules, then played cycle by cycle.
module tb_mc_control_fsm;
  localparam int MT = 4;

  localparam logic [3:0] S_IDLE = 4'd0,  S_FETCH = 4'd1,  S_DECODE = 4'd2, S_MEMADR = 4'd3;
  localparam logic [3:0] S_MEMRD = 4'd4, S_MEMWB = 4'd5,  S_MEMWR = 4'd6,  S_REX = 4'd7;
  localparam logic [3:0] S_RWB = 4'd8,   S_BRANCH = 4'd9, S_IEX = 4'd10,   S_IWB = 4'd11;
  localparam logic [3:0] S_JUMP = 4'd12, S_TRAP = 4'd13;

  localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_BEQ = 6'b000100, OP_BNE = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000, OP_SLTI = 6'b001010, OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI = 6'b001101, OP_LUI = 6'b001111, OP_LW = 6'b100011, OP_SW = 6'b101011;

  typedef struct packed {
    logic       pc_we, ir_we, mem_rd, mem_wr, iord;
    logic [1:0] ext_mode;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic       reg_we, reg_dst, mem_to_reg, trap;
  } ctl_t;

  typedef struct packed {
    logic [3:0] st;
    ctl_t       c;
    logic       rdy;
    logic       az;
    logic [5:0] op;
  } item_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mc_control_fsm_if bus();

  mc_control_fsm #(.MEM_TIMEOUT(MT)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .ctl     (bus.master)
  );

  item_t q[$];
  int n_checks = 0;
  int n_fail = 0;
  logic [5:0] legal_ops [10];

  function automatic ctl_t observed();
    ctl_t o;
    o.pc_we = bus.pc_we;       o.ir_we = bus.ir_we;         o.mem_rd = bus.mem_rd;
    o.mem_wr = bus.mem_wr;     o.iord = bus.iord;           o.ext_mode = bus.ext_mode;
    o.alu_src_a = bus.alu_src_a; o.alu_src_b = bus.alu_src_b; o.alu_op = bus.alu_op;
    o.pc_src = bus.pc_src;     o.reg_we = bus.reg_we;       o.reg_dst = bus.reg_dst;
    o.mem_to_reg = bus.mem_to_reg; o.trap = bus.trap;
    return o;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [3:0] st, input ctl_t c, input logic rdy, input logic az, input logic [5:0] op);
    item_t it;
    it.st = st; it.c = c; it.rdy = rdy; it.az = az; it.op = op;
    q.push_back(it);
  endtask

  task automatic plan_trap(input logic [5:0] op);
    ctl_t c;
    c = '0;
    c.trap = 1'b1;
    for (int i = 0; i < 3; i++) push(S_TRAP, c, 1'($urandom), 1'($urandom), op);
  endtask

  // w cycles of mem_ready low, then one ready cycle; MT low cycles in a row means timeout.
  task automatic plan_wait(input logic [3:0] st, input ctl_t base, input int w,
                           input logic [5:0] op, output bit trapped);
    ctl_t d;
    int n;
    n = (w < MT) ? w : MT;
    for (int i = 0; i < n; i++) push(st, base, 1'b0, 1'($urandom), op);
    trapped = (w >= MT);
    if (!trapped) begin
      d = base;
      if (st == S_FETCH) begin
        d.ir_we = 1'b1;
        d.pc_we = 1'b1;
      end
      push(st, d, 1'b1, 1'($urandom), op);
    end
  endtask

  task automatic imm_sel(input logic [5:0] op, output logic [1:0] ext, output logic [2:0] aop);
    case (op)
      OP_ADDI: begin ext = 2'b00; aop = 3'b000; end
      OP_SLTI: begin ext = 2'b00; aop = 3'b101; end
      OP_ANDI: begin ext = 2'b01; aop = 3'b011; end
      OP_ORI:  begin ext = 2'b01; aop = 3'b100; end
      default: begin ext = 2'b10; aop = 3'b110; end
    endcase
  endtask

  task automatic plan_instr(input logic [5:0] op, input int fw, input int mw, input logic az,
                            output bit trapped);
    ctl_t c;
    bit t;
    trapped = 1'b0;
    c = '0; c.mem_rd = 1'b1; c.alu_src_b = 2'b01;
    plan_wait(S_FETCH, c, fw, 6'($urandom), t);
    if (t) begin plan_trap(op); trapped = 1'b1; return; end
    c = '0; c.alu_src_b = 2'b11;
    push(S_DECODE, c, 1'($urandom), az, op);
    case (op)
      OP_LW, OP_SW: begin
        c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
        push(S_MEMADR, c, 1'($urandom), az, op);
        c = '0; c.iord = 1'b1;
        if (op == OP_LW) c.mem_rd = 1'b1; else c.mem_wr = 1'b1;
        plan_wait((op == OP_LW) ? S_MEMRD : S_MEMWR, c, mw, op, t);
        if (t) begin
          plan_trap(op);
          trapped = 1'b1;
        end else if (op == OP_LW) begin
          c = '0; c.reg_we = 1'b1; c.mem_to_reg = 1'b1;
          push(S_MEMWB, c, 1'($urandom), az, op);
        end
      end
      OP_R: begin
        c = '0; c.alu_src_a = 1'b1; c.alu_op = 3'b010;
        push(S_REX, c, 1'($urandom), az, op);
        c = '0; c.reg_we = 1'b1; c.reg_dst = 1'b1;
        push(S_RWB, c, 1'($urandom), az, op);
      end
      OP_BEQ, OP_BNE: begin
        c = '0; c.alu_src_a = 1'b1; c.alu_op = 3'b001; c.pc_src = 2'b01;
        c.pc_we = (op == OP_BEQ) ? az : !az;
        push(S_BRANCH, c, 1'($urandom), az, op);
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: begin
        c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
        imm_sel(op, c.ext_mode, c.alu_op);
        push(S_IEX, c, 1'($urandom), az, op);
        c.reg_we = 1'b1;
        push(S_IWB, c, 1'($urandom), az, op);
      end
      OP_J: begin
        c = '0; c.pc_src = 2'b10; c.pc_we = 1'b1;
        push(S_JUMP, c, 1'($urandom), az, op);
      end
      default: begin
        plan_trap(op);
        trapped = 1'b1;
      end
    endcase
  endtask

  // Plays up to n queued cycles (n < 0: all), then discards the rest.
  task automatic run(input int n);
    item_t it;
    int k;
    k = 0;
    while (q.size() > 0 && (n < 0 || k < n)) begin
      it = q.pop_front();
      bus.mem_ready = it.rdy;
      bus.alu_zero  = it.az;
      bus.opcode    = it.op;
      bus.funct     = 6'($urandom);
      @(negedge clk);
      check($sformatf("state(exp st%0d)", it.st), 32'(bus.state), 32'(it.st));
      check($sformatf("ctl(st%0d op%b)", it.st, it.op), 32'(observed()), 32'(it.c));
      @(posedge clk);
      #1;
      k++;
    end
    q.delete();
  endtask

  task automatic do_reset();
    ctl_t z;
    z = '0;
    rst_n = 1'b0;
    #1;
    check("reset_state_async", 32'(bus.state), 32'(S_IDLE));
    check("reset_ctl_async", 32'(observed()), 32'(z));
    @(posedge clk);
    #1;
    check("reset_state_held", 32'(bus.state), 32'(S_IDLE));
    rst_n = 1'b1;
    push(S_IDLE, z, 1'($urandom), 1'($urandom), 6'($urandom));
  endtask

  initial begin
    bit tr;
    ctl_t zc;
    logic [5:0] op;
    int fw, mw;
    zc = '0;
    legal_ops = '{OP_R, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI, OP_LW};
    bus.mem_ready = 1'b0; bus.alu_zero = 1'b0; bus.opcode = 6'd0; bus.funct = 6'd0;
    @(posedge clk);
    #1;
    do_reset();

    // R-type add, no memory stalls
    plan_instr(OP_R, 0, 0, 1'b0, tr);
    run(-1);
    // lw with three stalled cycles in MEMRD
    plan_instr(OP_LW, 0, 3, 1'b0, tr);
    run(-1);
    // ori then lui
    plan_instr(OP_ORI, 1, 0, 1'b0, tr);
    plan_instr(OP_LUI, 0, 0, 1'b1, tr);
    run(-1);
    // beq taken, bne not taken (both alu_zero=1), then bne taken
    plan_instr(OP_BEQ, 0, 0, 1'b1, tr);
    plan_instr(OP_BNE, 0, 0, 1'b1, tr);
    plan_instr(OP_BNE, 2, 0, 1'b0, tr);
    run(-1);
    // sw completing on the last allowed wait cycle, then jump
    plan_instr(OP_SW, MT - 1, MT - 1, 1'b0, tr);
    plan_instr(OP_J, 0, 0, 1'b0, tr);
    run(-1);
    // fetch timeout
    plan_instr(OP_R, 20, 0, 1'b0, tr);
    run(-1);
    check("timeout_trap_flag", 32'(bus.trap), 32'd1);
    do_reset();
    // illegal opcode
    plan_instr(6'b111111, 0, 0, 1'b0, tr);
    run(-1);
    do_reset();
    // reset in the middle of a stalled store
    plan_instr(OP_SW, 0, 3, 1'b0, tr);
    run(4);
    check("memwr_before_reset", 32'(bus.mem_wr), 32'd1);
    do_reset();
    plan_instr(OP_ADDI, 0, 0, 1'b0, tr);
    run(-1);

    // randomized instruction stream
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      else if ($urandom_range(0, 5) == 0) op = OP_SW;
      else op = legal_ops[$urandom_range(0, 9)];
      fw = ($urandom_range(0, 15) == 0) ? MT + 1 : $urandom_range(0, MT - 1);
      mw = ($urandom_range(0, 15) == 0) ? MT : $urandom_range(0, MT - 1);
      plan_instr(op, fw, mw, 1'($urandom), tr);
      run(-1);
      if (tr) do_reset();
    end
    run(-1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
